// File: rtl/packet_buffer_lane_allocator.sv
// Per-packet lane allocator: tracks free bytes per lane and locks one lane per
// packet, chosen round-robin among lanes able to hold a maximum-length frame.
module packet_buffer_lane_allocator #(
   parameter int unsigned NUM_LANES             = 8,
   parameter int unsigned AXI_WIDTH             = 64,
   parameter int unsigned LANE_DEPTH_BYTES      = 4096,
   parameter int unsigned MAX_PACKET_BYTES      = 1518,
   parameter int unsigned LANE_SELECT_IDX_WIDTH = $clog2(NUM_LANES)
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    in_valid_i,
   input  logic                                    in_last_i,
   output logic                                    in_ready_o,
   output logic [LANE_SELECT_IDX_WIDTH-1:0]        lane_sel_o,
   output logic [NUM_LANES-1:0]                    lane_wr_en_o,
   input  logic [NUM_LANES-1:0]                    lane_rd_i,
   output logic [$clog2(LANE_DEPTH_BYTES+1)-1:0]   lane_free_o [NUM_LANES],
   output logic                                    busy_o,
   output logic                                    err_o
);

   localparam int unsigned LSW       = LANE_SELECT_IDX_WIDTH;
   localparam int unsigned SUM_W     = LSW + 1;
   localparam int unsigned BPB       = AXI_WIDTH / 8;
   localparam int unsigned MAX_BEATS = (MAX_PACKET_BYTES + BPB - 1) / BPB;
   localparam int unsigned THRESH    = MAX_BEATS * BPB;
   localparam int unsigned FREE_W    = $clog2(LANE_DEPTH_BYTES + 1);
   localparam int unsigned BCW       = $clog2(MAX_BEATS + 1);

   localparam logic [FREE_W-1:0] DEPTH_V  = FREE_W'(LANE_DEPTH_BYTES);
   localparam logic [FREE_W-1:0] THRESH_V = FREE_W'(THRESH);
   localparam logic [FREE_W-1:0] BPB_V    = FREE_W'(BPB);
   localparam logic [BCW-1:0]    MAXB_V   = BCW'(MAX_BEATS);
   localparam logic [SUM_W-1:0]  NL_V     = SUM_W'(NUM_LANES);
   localparam logic [LSW-1:0]    LAST_V   = LSW'(NUM_LANES - 1);

   typedef enum logic [1:0] {IDLE, ALLOC, STREAM} state_t;

   state_t               state_q, state_d;
   logic [LSW-1:0]       rr_ptr_q, lane_q, grant_idx, rr_idx;
   logic [SUM_W-1:0]     rr_sum;
   logic                 grant_vld, handshake, oversize, err_q;
   logic [BCW-1:0]       beat_cnt_q;
   logic [NUM_LANES-1:0] eligible, rd_ok, underflow;
   logic [FREE_W-1:0]    free_q [NUM_LANES];
   logic [FREE_W-1:0]    free_d [NUM_LANES];

   assign in_ready_o = (state_q == STREAM);
   assign busy_o     = (state_q == STREAM);
   assign handshake  = in_valid_i && in_ready_o;
   assign oversize   = handshake && (beat_cnt_q == MAXB_V);
   assign lane_sel_o = lane_q;
   assign err_o      = err_q;

   // Per-lane eligibility, read gating, write strobes and free-counter next value
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         eligible[i]     = (free_q[i] >= THRESH_V);
         rd_ok[i]        = lane_rd_i[i] && (free_q[i] < DEPTH_V);
         underflow[i]    = lane_rd_i[i] && (free_q[i] == DEPTH_V);
         lane_wr_en_o[i] = handshake && !rst_i && (lane_q == LSW'(i)) && (beat_cnt_q < MAXB_V);
         free_d[i]       = free_q[i];
         if (lane_wr_en_o[i]) free_d[i] = free_d[i] - BPB_V;
         if (rd_ok[i])        free_d[i] = free_d[i] + FREE_W'(1);
         lane_free_o[i]  = free_q[i];
      end
   end

   // Round-robin search upward from rr_ptr; descending scan keeps the nearest hit
   always_comb begin
      state_d   = state_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_sum    = '0;
      rr_idx    = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         rr_sum = SUM_W'(rr_ptr_q) + SUM_W'(k);
         if (rr_sum >= NL_V) rr_sum = rr_sum - NL_V;
         rr_idx = LSW'(rr_sum);
         if (eligible[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = rr_idx;
         end
      end
      case (state_q)
         IDLE:    if (in_valid_i) state_d = ALLOC;
         ALLOC:   if (grant_vld) state_d = STREAM;
         STREAM:  if (handshake && in_last_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lane_q     <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) free_q[i] <= DEPTH_V;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) free_q[i] <= free_d[i];
         if (state_q == ALLOC && grant_vld) begin
            lane_q     <= grant_idx;
            beat_cnt_q <= '0;
         end else if (handshake && beat_cnt_q != MAXB_V) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
         end
         if (handshake && in_last_i)
            rr_ptr_q <= (lane_q == LAST_V) ? '0 : lane_q + LSW'(1);
         if (oversize || (|underflow)) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_packet_buffer_lane_allocator.sv
// Bench for packet_buffer_lane_allocator: randomized packets and reads checked
// every cycle against a byte-accounting model of lanes and round-robin choice.
module tb_packet_buffer_lane_allocator;

   localparam int N        = 8;
   localparam int BPB      = 8;
   localparam int MAXB     = 190;
   localparam int THRESH   = 1520;
   localparam int DEPTH    = 4096;
   localparam int P_IDLE   = 0;
   localparam int P_ALLOC  = 1;
   localparam int P_STREAM = 2;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_last, in_ready, busy, err;
   logic [2:0]  lane_sel;
   logic [7:0]  lane_wr_en, lane_rd;
   logic [12:0] lane_free [N];

   always #5 clk = ~clk;

   packet_buffer_lane_allocator dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_last_i    (in_last),
      .in_ready_o   (in_ready),
      .lane_sel_o   (lane_sel),
      .lane_wr_en_o (lane_wr_en),
      .lane_rd_i    (lane_rd),
      .lane_free_o  (lane_free),
      .busy_o       (busy),
      .err_o        (err)
   );

   int   errors = 0;
   int   checks = 0;
   int   m_free [N];
   int   m_rr, m_lane, m_beats, m_phase;
   logic m_err;
   int   hs_seen;
   int   wr_seen [N];
   int   grant_cnt [N];
   int   last_grant, last_latency;
   logic obs_ready;
   logic [2:0] obs_sel;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_free[i] = DEPTH;
      m_rr = 0; m_lane = 0; m_beats = 0; m_phase = P_IDLE; m_err = 1'b0;
   endtask

   task automatic clear_obs();
      hs_seen = 0;
      for (int i = 0; i < N; i++) begin wr_seen[i] = 0; grant_cnt[i] = 0; end
   endtask

   // One clock: drive, compare against the model mid-cycle, advance the model
   task automatic step(input logic r, input logic v, input logic l, input logic [7:0] rd);
      logic       exp_rdy, hs, ok, found;
      logic [7:0] exp_wr;
      int         nf [N];
      int         c;
      rst = r; in_valid = v; in_last = l; lane_rd = rd;
      #2;
      exp_rdy = (m_phase == P_STREAM);
      hs      = v && exp_rdy;
      exp_wr  = (!r && hs && m_beats < MAXB) ? 8'(1 << m_lane) : 8'h00;
      checks++;
      if (lane_wr_en !== exp_wr) begin
         errors++; $display("FAIL wr_en: got %b expected %b", lane_wr_en, exp_wr);
      end
      if (!r) begin
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++; $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
         end
         checks++;
         if (busy !== exp_rdy) begin
            errors++; $display("FAIL busy: got %b expected %b", busy, exp_rdy);
         end
         checks++;
         if (err !== m_err) begin
            errors++; $display("FAIL err: got %b expected %b", err, m_err);
         end
         if (exp_rdy) begin
            checks++;
            if (lane_sel !== 3'(m_lane)) begin
               errors++; $display("FAIL lane_sel: got %0d expected %0d", lane_sel, m_lane);
            end
         end
         for (int i = 0; i < N; i++) begin
            checks++;
            if (lane_free[i] !== 13'(m_free[i])) begin
               errors++; $display("FAIL free[%0d]: got %0d expected %0d", i, lane_free[i], m_free[i]);
            end
         end
      end
      obs_ready = in_ready;
      obs_sel   = lane_sel;
      if (!r && in_valid && in_ready) hs_seen++;
      for (int i = 0; i < N; i++) if (lane_wr_en[i] === 1'b1) wr_seen[i]++;
      if (r) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++) begin
            ok = rd[i] && (m_free[i] < DEPTH);
            if (rd[i] && !ok) m_err = 1'b1;
            nf[i] = m_free[i] - (exp_wr[i] ? BPB : 0) + (ok ? 1 : 0);
         end
         if (hs && m_beats >= MAXB) m_err = 1'b1;
         case (m_phase)
            P_IDLE:  if (v) m_phase = P_ALLOC;
            P_ALLOC: begin
               found = 1'b0;
               for (int k = 0; k < N; k++) begin
                  c = (m_rr + k) % N;
                  if (!found && m_free[c] >= THRESH) begin
                     found = 1'b1; m_lane = c; m_beats = 0; m_phase = P_STREAM;
                  end
               end
            end
            default: if (hs) begin
               m_beats++;
               if (l) begin m_phase = P_IDLE; m_rr = (m_lane + 1) % N; end
            end
         endcase
         for (int i = 0; i < N; i++) m_free[i] = nf[i];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   // Sends nbeats beats (valid gaps inside the packet), records grant and latency
   task automatic run_packet(input int nbeats, input bit with_last, input int rd_pct);
      int         sent, steps;
      bit         seen;
      logic       v, l;
      logic [7:0] rd;
      sent = 0; steps = 0; seen = 0; last_latency = -1; last_grant = -1;
      while (sent < nbeats && steps < 20000) begin
         for (int i = 0; i < N; i++) rd[i] = ($urandom_range(99) < rd_pct);
         v = (m_phase != P_STREAM) ? 1'b1 : ($urandom_range(3) != 0);
         l = v && with_last && (sent == nbeats - 1);
         if (v && m_phase == P_STREAM) sent++;
         step(1'b0, v, l, rd);
         if (!seen && obs_ready === 1'b1) begin
            seen = 1; last_latency = steps; last_grant = int'(obs_sel); grant_cnt[obs_sel]++;
         end
         steps++;
      end
      checks++;
      if (sent != nbeats) begin
         errors++; $display("FAIL packet_timeout: sent %0d expected %0d", sent, nbeats);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (lane_sel !== 3'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", lane_sel); end
      checks++; if (lane_wr_en !== 8'h00) begin errors++; $display("FAIL rst_wr: got %b expected 0", lane_wr_en); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (lane_free[i] !== 13'd4096) begin
            errors++; $display("FAIL rst_free[%0d]: got %0d expected 4096", i, lane_free[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset(); clear_obs();
      for (int p = 0; p < 3; p++) begin
         run_packet(4, 1'b1, 0);
         checks++;
         if (last_grant != p) begin errors++; $display("FAIL b2b_grant: got %0d expected %0d", last_grant, p); end
         checks++;
         if (last_latency != 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", last_latency); end
      end
      checks++; if (lane_free[0] !== 13'd4064) begin errors++; $display("FAIL b2b_free0: got %0d expected 4064", lane_free[0]); end
      checks++; if (lane_free[2] !== 13'd4064) begin errors++; $display("FAIL b2b_free2: got %0d expected 4064", lane_free[2]); end
      checks++; if (wr_seen[0] != 4) begin errors++; $display("FAIL b2b_wr0: got %0d expected 4", wr_seen[0]); end
   endtask

   task automatic test_simul_rw();
      do_reset();
      run_packet(1, 1'b1, 0);
      run_packet(1, 1'b1, 0);
      run_packet(137, 1'b0, 0);
      checks++; if (last_grant != 2) begin errors++; $display("FAIL rw_grant: got %0d expected 2", last_grant); end
      checks++; if (lane_free[2] !== 13'd3000) begin errors++; $display("FAIL rw_pre: got %0d expected 3000", lane_free[2]); end
      step(1'b0, 1'b1, 1'b0, 8'h04);
      checks++; if (lane_free[2] !== 13'd2993) begin errors++; $display("FAIL rw_net: got %0d expected 2993", lane_free[2]); end
      run_packet(1, 1'b1, 0);
   endtask

   task automatic test_oversize();
      do_reset(); clear_obs();
      run_packet(200, 1'b1, 0);
      checks++; if (last_grant != 0) begin errors++; $display("FAIL ovr_grant: got %0d expected 0", last_grant); end
      checks++; if (hs_seen != 200) begin errors++; $display("FAIL ovr_hs: got %0d expected 200", hs_seen); end
      checks++; if (wr_seen[0] != 190) begin errors++; $display("FAIL ovr_wr: got %0d expected 190", wr_seen[0]); end
      checks++; if (lane_free[0] !== 13'd2576) begin errors++; $display("FAIL ovr_free: got %0d expected 2576", lane_free[0]); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b expected 1", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_idle: got %b expected 0", busy); end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, 1'b0, 1'b0, 8'h20);
      checks++; if (lane_free[5] !== 13'd4096) begin errors++; $display("FAIL udf_free: got %0d expected 4096", lane_free[5]); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL udf_err: got %b expected 1", err); end
   endtask

   task automatic test_reset_mid_stream();
      run_packet(1, 1'b1, 0);
      run_packet(3, 1'b0, 0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
      step(1'b1, 1'b1, 1'b0, 8'h00);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (lane_free[i] !== 13'd4096) begin
            errors++; $display("FAIL mid_free[%0d]: got %0d expected 4096", i, lane_free[i]);
         end
      end
      run_packet(4, 1'b1, 0);
      checks++; if (last_grant != 0) begin errors++; $display("FAIL mid_grant: got %0d expected 0", last_grant); end
   endtask

   task automatic test_exhaustion();
      do_reset(); clear_obs();
      for (int p = 0; p < 16; p++) run_packet(190, 1'b1, 0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (grant_cnt[i] != 2) begin errors++; $display("FAIL exh_grants[%0d]: got %0d expected 2", i, grant_cnt[i]); end
         checks++;
         if (lane_free[i] !== 13'd1056) begin errors++; $display("FAIL exh_free[%0d]: got %0d expected 1056", i, lane_free[i]); end
      end
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exh_stall: got %b expected 0", in_ready); end
      for (int c = 0; c < 464; c++) step(1'b0, 1'b1, 1'b0, 8'h08);
      checks++; if (lane_free[3] !== 13'd1520) begin errors++; $display("FAIL exh_recover: got %0d expected 1520", lane_free[3]); end
      run_packet(4, 1'b1, 0);
      checks++; if (last_grant != 3) begin errors++; $display("FAIL exh_grant: got %0d expected 3", last_grant); end
   endtask

   task automatic test_random();
      int total;
      do_reset(); clear_obs();
      total = 0;
      for (int p = 0; p < 20; p++) begin
         int len;
         len = $urandom_range(220, 1);
         total += len;
         run_packet(len, 1'b1, 20);
         if ($urandom_range(1) == 1) step(1'b0, 1'b0, 1'b0, 8'($urandom));
      end
      checks++; if (hs_seen != total) begin errors++; $display("FAIL rnd_beats: got %0d expected %0d", hs_seen, total); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; lane_rd = 8'h00;
      model_reset(); clear_obs();
      test_reset();
      test_back_to_back();
      test_simul_rw();
      test_oversize();
      test_underflow();
      test_reset_mid_stream();
      test_exhaustion();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/packet_buffer_lane_allocator.md
# packet_buffer_lane_allocator

Per-packet lane allocator for the packet buffer. It sits between the ingress skid buffer and the per-lane FIFOs. It tracks the free byte space of every lane from write beats and output-side reads, then picks a lane round-robin for each new packet among lanes that can hold a maximum-length frame. The chosen lane stays locked until `tlast`, so one packet never straddles two lanes.

## Interface
- `NUM_LANES`, default 8: number of buffer lanes.
- `AXI_WIDTH`, default 64: ingress beat width in bits. `BPB = AXI_WIDTH/8` bytes per beat.
- `LANE_DEPTH_BYTES`, default 4096: capacity of one lane FIFO in bytes.
- `MAX_PACKET_BYTES`, default 1518: largest legal frame. `MAX_BEATS = ceil(MAX_PACKET_BYTES/BPB)`.
- `LANE_SELECT_IDX_WIDTH`, default `$clog2(NUM_LANES)`: lane index width.
- Derived: `FREE_W = $clog2(LANE_DEPTH_BYTES+1)`. `THRESH = MAX_BEATS*BPB`.

Ports:
- `clk_i` input 1: the only clock.
- `rst_i` input 1: synchronous, active-high reset.
- `in_valid_i` input 1: ingress beat valid.
- `in_last_i` input 1: ingress last beat of packet.
- `in_ready_o` output 1: ingress ready.
- `lane_sel_o` output `LANE_SELECT_IDX_WIDTH`: locked lane. Meaningful only while `busy_o` is high.
- `lane_wr_en_o[NUM_LANES]` output 1 each: write strobe to the lane FIFO.
- `lane_rd_i[NUM_LANES]` input 1 each: one byte consumed from that lane this cycle.
- `lane_free_o[NUM_LANES]` output `FREE_W` each: current free-byte count per lane.
- `busy_o` output 1: high while the FSM is in STREAM.
- `err_o` output 1: sticky error flag, cleared only by reset.

## Operation
- FSM states are IDLE, ALLOC and STREAM.
  - IDLE: leave for ALLOC on the next edge when `in_valid_i=1`.
  - ALLOC: form the eligible mask, bit i = (`free[i] >= THRESH`). If the mask is non-zero, grant the first set bit searching upward from `rr_ptr`, with wrap-around. Latch that bit as `lane_q` and go to STREAM. If the mask is zero, stay in ALLOC and re-evaluate every cycle.
  - STREAM: `in_ready_o=1`. Each handshake (`in_valid_i && in_ready_o`) is one beat.
    - A beat with `in_last_i=1` returns the FSM to IDLE and sets `rr_ptr = lane_q+1`, taken modulo `NUM_LANES`.
- `lane_wr_en_o[i] = handshake && (i == lane_q) && (beat_cnt < MAX_BEATS)`. This is combinational from the handshake.
- `beat_cnt` clears on entry to STREAM and increments on every handshake. It saturates at `MAX_BEATS`.
- Oversize packets: beats beyond `MAX_BEATS` are still accepted. Their writes are suppressed, they are discarded, and `err_o` is set. The packet stays on `lane_q` until `in_last_i`.
- Free counter update, evaluated every cycle for every lane: `free[i] <= free[i] - (wr_en[i] ? BPB : 0) + (rd_ok[i] ? 1 : 0)`.
  - `rd_ok[i] = lane_rd_i[i] && (free[i] < LANE_DEPTH_BYTES)`.
  - A read while `free[i] == LANE_DEPTH_BYTES` is an underflow: it is ignored and sets `err_o`.
- A write and a read on the same lane in the same cycle apply together, for a net change of `-BPB+1`.
- The free counter cannot underflow: `THRESH` reserves space for a full packet, and writes are capped at `MAX_BEATS`.
- `lane_free_o[i] = free[i]`, driven from the register.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `lane_q=0`, `beat_cnt=0`, `free[*]=LANE_DEPTH_BYTES`, `err_o=0`.
- Output values during and after reset: `in_ready_o=0`, `busy_o=0`, `lane_wr_en_o[*]=0`, `lane_sel_o=0`.
- Reset mid-packet: all of the above values apply on the next edge. The partial packet is abandoned.
- Allocation latency:
  - `in_valid_i` sampled high in IDLE at edge N gives ALLOC at N+1.
  - With an eligible lane, STREAM and `in_ready_o=1` follow at N+2. The first beat can be accepted in the N+2 cycle.
  - A stall in ALLOC extends this one cycle per ineligible evaluation.
- Packet boundaries: after a `tlast` beat, `in_ready_o` is low for at least 2 cycles (IDLE, then ALLOC). Full throughput applies only within a packet.
- Free-counter visibility: `lane_free_o` reflects a write or read one cycle after the strobe. ALLOC uses the registered value.
- `in_ready_o` and `busy_o` are decoded from registered state only.

## Test plan
Default parameters give `BPB=8`, `MAX_BEATS=190` and `THRESH=1520`.
- **Basic allocation:** reset, then three back-to-back 4-beat packets -> grants to lanes 0, 1, 2. The first `in_ready_o` is 2 cycles after `in_valid_i`. `lane_free_o[0]=4064`. Exactly 4 `lane_wr_en_o[0]` pulses.
- **Exhaustion and recovery:** sixteen 190-beat packets with no reads -> each lane is granted twice and every `free=1056`. A 17th packet stalls in ALLOC with `in_ready_o=0`. Then pulse `lane_rd_i[3]` 464 times -> free reaches 1520, lane 3 is granted, and streaming resumes.
- **Simultaneous read/write:** a write beat to lane 2 and `lane_rd_i[2]` in the same cycle, starting from `free=3000` -> `lane_free_o[2]=2993` next cycle.
- **Oversize packet:** a 200-beat packet on lane 0 -> 200 handshakes, 190 write pulses, `free[0]=2576`, `err_o=1`, return to IDLE after beat 200.
- **Read underflow:** `lane_rd_i[5]=1` with `free[5]=4096` -> `free[5]` stays 4096 and `err_o=1`.
- **Reset mid-STREAM:** assert `rst_i` at beat 3 of a packet -> next cycle `in_ready_o=0`, `busy_o=0`, `free[*]=4096`, `err_o=0`. The next packet is granted lane 0.
